// File: rtl/seq_generator.sv
// Serial pattern generator: shifts a captured bit pattern out MSB-first
// (bit len-1 first), repeating it reps+1 times back to back, then pulses
// done for one cycle. Output is meant to feed a serial sequence detector.
//
// Handshake: start is a request sampled only while idle; the request is
// accepted on the edge where start=1 in IDLE, and the first bit appears on
// out (with out_valid=1) in the very next cycle. There is no ready signal:
// busy=1 means further start requests are dropped, not queued.
module seq_generator #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    input  logic [3:0]                 reps,
    output logic                       out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 o_dbg_state
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;
    logic [LW-1:0]    r_len;
    logic [IW-1:0]    r_idx;     // index of the bit currently on out
    logic [3:0]       r_rep;     // repetitions still to send after this one
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [LW-1:0]    w_len_sat;
    logic [IW-1:0]    w_start_idx;
    logic [IW-1:0]    w_reload_idx;
    logic [IW-1:0]    w_next_idx;

    // Oversized lengths are clamped to the pattern width.
    assign w_len_sat    = (len > LEN_MAX) ? LEN_MAX : len;
    assign w_start_idx  = IW'(w_len_sat - 1'b1);
    assign w_reload_idx = IW'(r_len - 1'b1);
    assign w_next_idx   = r_idx - 1'b1;

    // Single FSM: next state, counters and registered outputs together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_rep   <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    // abort wins over start: stay idle
                    if (start && !abort) begin
                        r_pat  <= pattern;
                        r_len  <= w_len_sat;
                        r_rep  <= reps;
                        r_busy <= 1'b1;
                        if (w_len_sat == '0) begin
                            // empty request: straight to the done pulse
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_idx   <= w_start_idx;
                            r_out   <= pattern[w_start_idx];
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_out   <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (r_idx != '0) begin
                        r_idx <= w_next_idx;
                        r_out <= r_pat[w_next_idx];
                    end else if (r_rep != 4'd0) begin
                        // next repetition starts with no gap cycle
                        r_rep <= r_rep - 4'd1;
                        r_idx <= w_reload_idx;
                        r_out <= r_pat[w_reload_idx];
                    end else begin
                        r_state <= S_DONE;
                        r_out   <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // start is not sampled here; earliest restart is from IDLE
                    r_state <= S_IDLE;
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out         = r_out;
    assign out_valid   = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_generator.sv
// Testbench for seq_generator: scenario tasks checked against a bit-queue
// reference model built directly from pattern/len/reps.
module tb_seq_generator;

    localparam int WIDTH = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len     = '0;
    logic [3:0] reps    = '0;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [0:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    seq_generator #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .o_dbg_state(dbg_state)
    );

    // Reference model: the stream is simply (reps+1) copies of
    // pattern[min(len,8)-1 : 0], most significant bit first.
    function automatic void model_build(input logic [7:0] p, input int l, input int r);
        int l_eff;
        exp_q.delete();
        l_eff = (l > WIDTH) ? WIDTH : l;
        for (int k = 0; k <= r; k++)
            for (int i = l_eff - 1; i >= 0; i--)
                exp_q.push_back(p[i]);
    endfunction

    // driver: advance one cycle, land 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: present a request for one edge; returns in cycle 1
    task automatic drive_start(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        pattern = 8'hFF;
        len     = 4'd8;
        start   = 1'b1;
        step();
        step();
        n_cmp++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset: out/valid/busy/done=%b want 0000", {out, out_valid, busy, done});
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: valid/busy/done=%b want 000", {out_valid, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [3:0] spec_bits;
        int c;
        spec_bits = 4'b1101;
        model_build(8'h0D, 4, 0);
        drive_start(8'h0D, 4'd4, 4'd0);
        c = 0;
        while (exp_q.size() > 0) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== e || out !== spec_bits[3-c] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic bit%0d: out=%b valid=%b busy=%b want out=%b valid=1 busy=1",
                         c, out, out_valid, busy, e);
            end
            c++;
            step();
        end
        n_cmp++;
        if ({done, out_valid, out, busy} !== 4'b1001) begin
            n_err++;
            $display("FAIL basic done_cycle: done/valid/out/busy=%b want 1001", {done, out_valid, out, busy});
        end
        step();
        n_cmp++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL basic idle_after: busy/done/valid=%b want 000", {busy, done, out_valid});
        end
    endtask

    task automatic test_reps();
        int c;
        model_build(8'h0D, 4, 1);
        drive_start(8'h0D, 4'd4, 4'd1);
        c = 0;
        while (exp_q.size() > 0) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== e) begin
                n_err++;
                $display("FAIL reps bit%0d: out=%b valid=%b want out=%b valid=1", c, out, out_valid, e);
            end
            c++;
            step();
        end
        n_cmp++;
        if (c != 8 || done !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reps done: bits=%0d done=%b valid=%b want bits=8 done=1 valid=0", c, done, out_valid);
        end
        step();
    endtask

    task automatic test_len_zero();
        drive_start(8'hA5, 4'd0, 4'd3);
        n_cmp++;
        if ({done, out_valid, out, busy} !== 4'b1001) begin
            n_err++;
            $display("FAIL len0 cycle1: done/valid/out/busy=%b want 1001", {done, out_valid, out, busy});
        end
        step();
        n_cmp++;
        if ({done, out_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL len0 cycle2: done/valid/busy=%b want 000", {done, out_valid, busy});
        end
    endtask

    task automatic test_ignore_start();
        int c;
        model_build(8'hB6, 8, 0);
        drive_start(8'hB6, 4'd8, 4'd0);
        c = 1;
        while (exp_q.size() > 0) begin
            logic [0:0] e;
            if (c >= 3 && c <= 5) begin
                start   = 1'b1;
                pattern = 8'h49;
                len     = 4'd5;
                reps    = 4'd2;
            end else begin
                start = 1'b0;
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== e) begin
                n_err++;
                $display("FAIL ignore_start bit%0d: out=%b valid=%b want out=%b valid=1", c, out, out_valid, e);
            end
            c++;
            step();
        end
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_start done: done=%b want 1", done);
        end
        step();
    endtask

    task automatic test_abort();
        drive_start(8'h0D, 4'd4, 4'd0);
        step();
        abort = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 1'b1) begin
            n_err++;
            $display("FAIL abort cycle2: out=%b valid=%b want out=1 valid=1", out, out_valid);
        end
        step();
        abort = 1'b0;
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL abort cycle3: valid/busy/done=%b want 000", {out_valid, busy, done});
        end
        model_build(8'hA5, 3, 0);
        drive_start(8'hA5, 4'd3, 4'd0);
        while (exp_q.size() > 0) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== e) begin
                n_err++;
                $display("FAIL abort restart: out=%b valid=%b want out=%b valid=1", out, out_valid, e);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL abort restart_done: done=%b want 1", done);
        end
        step();
    endtask

    task automatic test_abort_priority();
        pattern = 8'h0D;
        len     = 4'd4;
        reps    = 4'd0;
        start   = 1'b1;
        abort   = 1'b1;
        step();
        start   = 1'b0;
        abort   = 1'b0;
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_priority: valid/busy/done=%b want 000", {out_valid, busy, done});
        end
        step();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_priority later: valid/busy=%b want 00", {out_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] det_sr;
        int n_valid;
        int n_done;
        drive_start(8'hB6, 4'd8, 4'd2);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid: out/valid/busy/done=%b want 0000", {out, out_valid, busy, done});
        end
        // loopback into a small serial detector: nothing more may arrive
        det_sr  = '0;
        n_valid = 0;
        n_done  = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid === 1'b1) begin
                det_sr = {det_sr[6:0], out};
                n_valid++;
            end
            if (done === 1'b1) n_done++;
            step();
        end
        n_cmp++;
        if (n_valid != 0 || n_done != 0) begin
            n_err++;
            $display("FAIL reset_mid loopback: bits=%0d dones=%0d det=%h want 0 0", n_valid, n_done, det_sr);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [7:0] p;
            logic [3:0] l;
            logic [3:0] r;
            int c;
            p = 8'($urandom);
            l = 4'($urandom_range(0, 15));
            r = 4'($urandom_range(0, 3));
            model_build(p, int'(l), int'(r));
            drive_start(p, l, r);
            c = 0;
            while (exp_q.size() > 0) begin
                logic [0:0] e;
                start   = 1'($urandom_range(0, 1));
                pattern = 8'($urandom);
                len     = 4'($urandom_range(0, 15));
                reps    = 4'($urandom_range(0, 15));
                e = exp_q.pop_front();
                n_cmp++;
                if (out_valid !== 1'b1 || out !== e || busy !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL random t%0d bit%0d (p=%h l=%0d r=%0d): out=%b valid=%b busy=%b done=%b want out=%b",
                             t, c, p, l, r, out, out_valid, busy, done, e);
                end
                c++;
                step();
            end
            // start may be high while in DONE; it must not be taken
            start = 1'($urandom_range(0, 1));
            n_cmp++;
            if ({done, out_valid, out, busy} !== 4'b1001) begin
                n_err++;
                $display("FAIL random t%0d done: done/valid/out/busy=%b want 1001", t, {done, out_valid, out, busy});
            end
            step();
            start = 1'b0;
            n_cmp++;
            if ({busy, out_valid, done} !== 3'b000) begin
                n_err++;
                $display("FAIL random t%0d idle: busy/valid/done=%b want 000", t, {busy, out_valid, done});
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_reps();
        test_len_zero();
        test_ignore_start();
        test_abort();
        test_abort_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
